// File: rtl/rv_ctrl_fsm.sv
// rv_ctrl_fsm: multi-cycle RV32I/RV64I control unit.
// Sequences one instruction at a time through DECODE, EXEC, MEM and WB and
// drives register-file, ALU, data-memory and PC-update controls.
// Optional feature macro: CTRL_MUL_EN (enables the OP/MUL encoding).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a new instruction; latches instr on handshake
// DECODE  | classify latched instruction; unsupported -> ILLEGAL
// EXEC    | ALU phase; branches resolve and update PC here
// MEM     | data-memory request held until mem_ack
// WB      | register write-back (rd != 0) and PC + 4 update
// ILLEGAL | one-cycle illegal pulse, no side effects
module rv_ctrl_fsm #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr,
  output logic [XLEN-1:0]     imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_imm,
  output logic [4:0]          rf_raddr1,
  output logic [4:0]          rf_raddr2,
  output logic [4:0]          rf_waddr,
  output logic                rf_we,
  output logic                rf_wsel_mem,
  output logic                mem_req,
  output logic                mem_we,
  input  logic                mem_ack,
  input  logic                branch_cond,
  output logic                pc_we,
  output logic                pc_sel_branch,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_ILLEGAL = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] LS_FUNCT3 = (XLEN == 64) ? 3'b011 : 3'b010;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = ALU_OP_W'(10);
`ifdef CTRL_MUL_EN
  localparam logic [ALU_OP_W-1:0] ALU_MUL   = ALU_OP_W'(11);
`endif

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic        store_pc_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic [XLEN-1:0]     imm_i, imm_s, imm_b, imm_u;
  logic [XLEN-1:0]     dec_imm;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_src_imm;
  logic                dec_illegal;
  logic                is_load, is_store, is_branch;
  logic                shamt_hi_zero, shamt_hi_sr_ok;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){ir[31]}}, ir[30:12], 12'b0};

  // Shift-immediate upper bits: RV64 has a 6-bit shamt, so one fewer bit must be zero.
  assign shamt_hi_zero  = (XLEN == 64) ? (ir[31:26] == 6'b0) : (ir[31:25] == 7'b0);
  assign shamt_hi_sr_ok = (XLEN == 64) ? ({ir[31], ir[29:26]} == 5'b0)
                                       : ({ir[31], ir[29:25]} == 6'b0);

  // funct3 -> ALU op shared by OP and OP-IMM; alt selects SUB/SRA.
  function automatic logic [ALU_OP_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [ALU_OP_W-1:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Latched-instruction decode: class, ALU op, operand select, immediate, legality.
  always_comb begin
    dec_illegal = 1'b1;
    dec_alu_op  = ALU_ADD;
    dec_src_imm = 1'b0;
    dec_imm     = '0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_branch   = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        dec_src_imm = 1'b1;
        dec_imm     = imm_i;
        dec_alu_op  = alu_from_f3(funct3, (funct3 == 3'b101) && ir[30]);
        if (funct3 == 3'b001)      dec_illegal = !shamt_hi_zero;
        else if (funct3 == 3'b101) dec_illegal = !shamt_hi_sr_ok;
        else                       dec_illegal = 1'b0;
      end
      OPC_OP: begin
        dec_alu_op = alu_from_f3(funct3, ir[30]);
        if (funct7 == 7'b0000000) begin
          dec_illegal = 1'b0;
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec_illegal = 1'b0;
        end
`ifdef CTRL_MUL_EN
        else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
          dec_illegal = 1'b0;
          dec_alu_op  = ALU_MUL;
        end
`endif
      end
      OPC_LUI: begin
        dec_illegal = 1'b0;
        dec_src_imm = 1'b1;
        dec_imm     = imm_u;
        dec_alu_op  = ALU_PASSB;
      end
      OPC_LOAD: begin
        dec_illegal = (funct3 != LS_FUNCT3);
        dec_src_imm = 1'b1;
        dec_imm     = imm_i;
        is_load     = 1'b1;
      end
      OPC_STORE: begin
        dec_illegal = (funct3 != LS_FUNCT3);
        dec_src_imm = 1'b1;
        dec_imm     = imm_s;
        is_store    = 1'b1;
      end
      OPC_BRANCH: begin
        dec_illegal = (funct3[2:1] != 2'b00);
        dec_imm     = imm_b;
        dec_alu_op  = ALU_SUB;
        is_branch   = 1'b1;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Instruction latch (only on handshake) and deferred store PC strobe,
  // which keeps pc_we free of any combinational path from mem_ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir         <= '0;
      store_pc_q <= 1'b0;
    end else begin
      if (state == S_IDLE && instr_valid) ir <= instr;
      store_pc_q <= (state == S_MEM) && mem_ack && is_store;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (instr_valid) state_nxt = S_DECODE;
      S_DECODE:  state_nxt = dec_illegal ? S_ILLEGAL : S_EXEC;
      S_EXEC: begin
        if (is_branch)                state_nxt = S_IDLE;
        else if (is_load || is_store) state_nxt = S_MEM;
        else                          state_nxt = S_WB;
      end
      S_MEM:     if (mem_ack) state_nxt = is_load ? S_WB : S_IDLE;
      S_WB:      state_nxt = S_IDLE;
      S_ILLEGAL: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output logic from state and latched instruction.
  always_comb begin
    imm           = dec_imm;
    alu_op        = dec_alu_op;
    alu_src_imm   = dec_src_imm;
    rf_raddr1     = ir[19:15];
    rf_raddr2     = ir[24:20];
    rf_waddr      = ir[11:7];
    instr_ready   = (state == S_IDLE);
    rf_we         = 1'b0;
    rf_wsel_mem   = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    pc_we         = store_pc_q;
    pc_sel_branch = 1'b0;
    illegal       = 1'b0;
    case (state)
      S_EXEC: begin
        if (is_branch) begin
          pc_we         = 1'b1;
          pc_sel_branch = branch_cond ^ funct3[0];
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
      end
      S_WB: begin
        rf_we       = (ir[11:7] != 5'd0);
        rf_wsel_mem = is_load;
        pc_we       = 1'b1;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Self-checking bench for rv_ctrl_fsm (default XLEN = 32).
// Expected values are queued when an instruction is issued and popped in
// order at each observation point. Define CTRL_MUL_EN to match the DUT build.
module tb_rv_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic        rf_we, rf_wsel_mem;
  logic        mem_req, mem_we, mem_ack;
  logic        branch_cond;
  logic        pc_we, pc_sel_branch, illegal;

  rv_ctrl_fsm #(.XLEN(32), .ALU_OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .imm(imm), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .rf_wsel_mem(rf_wsel_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .branch_cond(branch_cond),
    .pc_we(pc_we), .pc_sel_branch(pc_sel_branch), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_total  = 0;
  int   n_passed = 0;

  task automatic sb_push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    exp_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      $error("FAIL sb_empty: observed 0x%0h with no expected value queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) n_passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present w in an IDLE cycle (T) and return positioned in T+1.
  task automatic issue(input logic [31:0] w);
    instr_valid = 1'b1;
    instr       = w;
    sb_push("hs_ready", 1);
    sb_check(instr_ready);
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; mem_ack = 1'b0; branch_cond = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    sb_push("rst_ready", 1); sb_push("rst_imm", 0); sb_push("rst_alu_op", 0);
    sb_push("rst_src_imm", 0); sb_push("rst_rf_we", 0); sb_push("rst_pc_we", 0);
    sb_push("rst_mem_req", 0); sb_push("rst_illegal", 0);
    sb_check(instr_ready); sb_check(imm); sb_check(alu_op);
    sb_check(alu_src_imm); sb_check(rf_we); sb_check(pc_we);
    sb_check(mem_req); sb_check(illegal);
    rst_n = 1'b1;
    tick();

    // ADDI x1,x0,5 with instr_valid/mem_ack noise while busy
    issue(32'h00500093);
    sb_push("addi_imm", 5); sb_push("addi_alu_op", 0); sb_push("addi_src", 1);
    sb_push("addi_waddr", 1); sb_push("addi_we_t1", 0);
    sb_check(imm); sb_check(alu_op); sb_check(alu_src_imm); sb_check(rf_waddr); sb_check(rf_we);
    instr_valid = 1'b1; instr = 32'h123450B7; mem_ack = 1'b1;
    tick();
    sb_push("addi_imm_held", 5); sb_push("addi_we_t2", 0); sb_push("addi_pc_t2", 0);
    sb_check(imm); sb_check(rf_we); sb_check(pc_we);
    tick();
    instr_valid = 1'b0; mem_ack = 1'b0;
    sb_push("addi_we_t3", 1); sb_push("addi_pc_t3", 1); sb_push("addi_sel_t3", 0);
    sb_push("addi_wsel_t3", 0); sb_push("addi_ready_t3", 0);
    sb_check(rf_we); sb_check(pc_we); sb_check(pc_sel_branch); sb_check(rf_wsel_mem); sb_check(instr_ready);
    tick();
    sb_push("addi_ready_t4", 1); sb_push("addi_we_t4", 0); sb_push("addi_pc_t4", 0);
    sb_check(instr_ready); sb_check(rf_we); sb_check(pc_we);

    // ADDI x0,x0,5: no register write for rd = 0
    issue(32'h00500013);
    tick(); tick();
    sb_push("addi_x0_we", 0); sb_push("addi_x0_pc", 1);
    sb_check(rf_we); sb_check(pc_we);
    tick();

    // LW x5,-4(x1), ack in third MEM cycle
    issue(32'hFFC0A283);
    sb_push("lw_imm", 32'hFFFFFFFC); sb_push("lw_waddr", 5); sb_push("lw_raddr1", 1);
    sb_push("lw_alu_op", 0); sb_push("lw_src", 1);
    sb_check(imm); sb_check(rf_waddr); sb_check(rf_raddr1); sb_check(alu_op); sb_check(alu_src_imm);
    tick();
    sb_push("lw_req_exec", 0); sb_check(mem_req);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) mem_ack = 1'b1;
      sb_push("lw_req_mem", 1); sb_push("lw_we_mem", 0);
      sb_check(mem_req); sb_check(mem_we);
    end
    tick();
    mem_ack = 1'b0;
    sb_push("lw_wb_req", 0); sb_push("lw_wb_we", 1); sb_push("lw_wb_wsel", 1); sb_push("lw_wb_pc", 1);
    sb_check(mem_req); sb_check(rf_we); sb_check(rf_wsel_mem); sb_check(pc_we);
    tick();
    sb_push("lw_ready", 1); sb_push("lw_we_after", 0);
    sb_check(instr_ready); sb_check(rf_we);

    // SW x2,8(x1), immediate ack
    issue(32'h0020A423);
    sb_push("sw_imm", 8); sb_push("sw_raddr2", 2); sb_push("sw_raddr1", 1);
    sb_check(imm); sb_check(rf_raddr2); sb_check(rf_raddr1);
    tick(); tick();
    mem_ack = 1'b1;
    sb_push("sw_req", 1); sb_push("sw_mem_we", 1); sb_push("sw_rf_we", 0); sb_push("sw_pc_in_mem", 0);
    sb_check(mem_req); sb_check(mem_we); sb_check(rf_we); sb_check(pc_we);
    tick();
    mem_ack = 1'b0;
    sb_push("sw_pc_exit", 1); sb_push("sw_sel_exit", 0); sb_push("sw_req_exit", 0);
    sb_push("sw_rf_we_exit", 0); sb_push("sw_ready", 1);
    sb_check(pc_we); sb_check(pc_sel_branch); sb_check(mem_req); sb_check(rf_we); sb_check(instr_ready);
    tick();
    sb_push("sw_pc_once", 0); sb_check(pc_we);

    // BEQ/BNE x1,x2,+16 across branch_cond values
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      logic        cond, exp_sel;
      w       = (k < 2) ? 32'h00208863 : 32'h00209863;
      cond    = (k == 0 || k == 2);
      exp_sel = (k < 2) ? cond : !cond;
      branch_cond = cond;
      issue(w);
      sb_push("br_imm", 16); sb_push("br_alu_op", 1); sb_push("br_src", 0); sb_push("br_pc_t1", 0);
      sb_check(imm); sb_check(alu_op); sb_check(alu_src_imm); sb_check(pc_we);
      tick();
      sb_push("br_pc_t2", 1); sb_push("br_sel_t2", {63'b0, exp_sel}); sb_push("br_rf_we", 0);
      sb_check(pc_we); sb_check(pc_sel_branch); sb_check(rf_we);
      tick();
      sb_push("br_ready_t3", 1); sb_push("br_pc_t3", 0);
      sb_check(instr_ready); sb_check(pc_we);
    end
    branch_cond = 1'b0;

    // Illegal: all-ones word, SUB-only funct7 with SLL, LD on RV32
    for (int k = 0; k < 3; k++) begin
      logic [31:0] w;
      w = (k == 0) ? 32'hFFFFFFFF : (k == 1) ? 32'h402090B3 : 32'hFFC0B283;
      issue(w);
      sb_push("ill_t1", 0); sb_check(illegal);
      tick();
      sb_push("ill_t2", 1); sb_push("ill_pc", 0); sb_push("ill_rf_we", 0);
      sb_check(illegal); sb_check(pc_we); sb_check(rf_we);
      tick();
      sb_push("ill_t3", 0); sb_push("ill_ready", 1);
      sb_check(illegal); sb_check(instr_ready);
    end

    // Reset during EXEC of ADDI aborts it
    issue(32'h00500093);
    tick();
    rst_n = 1'b0;
    #1;
    sb_push("abort_ready", 1); sb_push("abort_we", 0); sb_push("abort_imm", 0);
    sb_check(instr_ready); sb_check(rf_we); sb_check(imm);
    tick();
    sb_push("abort_we_hold", 0); sb_push("abort_pc_hold", 0);
    sb_check(rf_we); sb_check(pc_we);
    rst_n = 1'b1;
    tick();
    sb_push("abort_we_after", 0); sb_push("abort_ready_after", 1);
    sb_check(rf_we); sb_check(instr_ready);

    // SUB, SRAI, LUI decode and write-back
    for (int k = 0; k < 3; k++) begin
      logic [31:0] w;
      logic [63:0] e_op, e_imm, e_src;
      case (k)
        0:       begin w = 32'h402080B3; e_op = 1;  e_imm = 0;           e_src = 0; end
        1:       begin w = 32'h4030D093; e_op = 7;  e_imm = 64'h403;     e_src = 1; end
        default: begin w = 32'h123450B7; e_op = 10; e_imm = 64'h12345000; e_src = 1; end
      endcase
      issue(w);
      sb_push("alu_op", e_op); sb_push("alu_imm", e_imm); sb_push("alu_src", e_src);
      sb_check(alu_op); sb_check(imm); sb_check(alu_src_imm);
      tick(); tick();
      sb_push("alu_wb_we", 1); sb_check(rf_we);
      tick();
    end

    // MUL x3,x1,x2
    issue(32'h022081B3);
`ifdef CTRL_MUL_EN
    sb_push("mul_alu_op", 11); sb_check(alu_op);
    tick();
    sb_push("mul_no_ill", 0); sb_check(illegal);
    tick();
    sb_push("mul_we", 1); sb_push("mul_waddr", 3);
    sb_check(rf_we); sb_check(rf_waddr);
`else
    tick();
    sb_push("mul_ill", 1); sb_check(illegal);
    tick();
    sb_push("mul_no_we", 0); sb_push("mul_ready", 1);
    sb_check(rf_we); sb_check(instr_ready);
`endif
    tick();

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/rv_ctrl_fsm.md
Name: rv_ctrl_fsm

Overview:
Multi-cycle RV32I/RV64I control unit and next generation of the single-instruction decoder. Accepts one instruction per handshake and decodes OP-IMM, OP, LUI, LOAD (LW/LD), STORE (SW/SD) and BRANCH (BEQ/BNE). Sequences the instruction through the DECODE, EXEC, MEM and WB phases. Drives register-file, ALU, data-memory and PC-update controls, and sits between the fetch unit and the datapath.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets immediate width and selects LW/SW (32) or LD/SD (64).
ALU_OP_W, 4, width of the alu_op encoding.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
instr_valid  in  1  fetch presents instr.
instr_ready  out  1  block can accept an instruction; high only in IDLE.
instr  in  32  instruction word, sampled on the handshake.
imm  out  XLEN  sign-extended immediate of the latched instruction.
alu_op  out  ALU_OP_W  ALU operation.
alu_src_imm  out  1  1 = ALU operand B is imm, 0 = rs2.
rf_raddr1  out  5  rs1 field.
rf_raddr2  out  5  rs2 field.
rf_waddr  out  5  rd field.
rf_we  out  1  register-file write enable.
rf_wsel_mem  out  1  1 = write-back data from memory, 0 = from ALU.
mem_req  out  1  data-memory request; held until mem_ack.
mem_we  out  1  1 = store, valid while mem_req is high.
mem_ack  in  1  data-memory completion.
branch_cond  in  1  ALU equality result (rs1 == rs2), sampled in EXEC.
pc_we  out  1  one-cycle PC update strobe.
pc_sel_branch  out  1  1 = PC + imm, 0 = PC + 4; valid with pc_we.
illegal  out  1  one-cycle pulse on an unsupported encoding.

Behaviour:
- Reset: all outputs 0 except instr_ready = 1. State = IDLE. Latched instruction register = 0.
- Reset asserted mid-operation aborts the instruction immediately; no rf_we or pc_we is issued for it.
- Outputs are Moore: a function of the state register and the latched instruction only. No combinational path from instr or mem_ack to any output.
- States and transitions:
  - IDLE: on instr_valid & instr_ready, latch instr and go to DECODE.
  - DECODE: classify the instruction. Unsupported encoding -> ILLEGAL; otherwise -> EXEC.
  - EXEC: BRANCH goes to IDLE, with pc_we = 1 and pc_sel_branch = branch_cond XOR funct3[0]. STORE/LOAD go to MEM. All others go to WB.
  - MEM: mem_req = 1, mem_we = store. Held while mem_ack = 0. On mem_ack = 1, a load goes to WB; a store goes to IDLE with pc_we = 1 and pc_sel_branch = 0.
  - WB: rf_we = 1 only if rd != 0; pc_we = 1; pc_sel_branch = 0; next state IDLE. rf_wsel_mem = 1 for loads.
  - ILLEGAL: illegal = 1 for one cycle, no rf_we and no pc_we, next state IDLE.
- Latency from the handshake in cycle T:
  - ALU ops: rf_we in T+3, instr_ready again in T+4.
  - Branch: pc_we in T+2.
  - Memory ops: MEM is entered at T+3; load WB follows the ack by one cycle.
- alu_op encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10, MUL 11.
- Decode rules:
  - SUB only for OP with instr[30] = 1 and funct3 = 000.
  - SRA/SRAI when funct3 = 101 and instr[30] = 1.
  - OP with funct7 other than 0000000 or 0100000 (where allowed) is illegal.
  - LOAD/STORE/BRANCH use ADD or SUB for address or compare.
  - LUI uses PASSB.
- Immediate formats (all sign-extended from instr[31] to XLEN):
  - I-type: instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type: {instr[31:12], 12'b0}.
- Load/store width: funct3 must be 010 for XLEN = 32, or 011 for XLEN = 64; any other value is illegal.
- mem_ack outside MEM is ignored. instr_valid while not ready is ignored and the instruction is not consumed.

Optional Feature:
CTRL_MUL_EN:
- Defined: OP with funct7 = 0000001 and funct3 = 000 decodes as MUL (alu_op 11, rf_we in WB, same latency as ADD).
- Undefined: that encoding takes the ILLEGAL path.

Test Plan:
- ADDI x1,x0,5 (0x00500093), handshake at T -> imm = 5, alu_op = 0, alu_src_imm = 1, rf_waddr = 1, rf_we = 1 only in T+3, instr_ready = 1 at T+4.
- LW x5,-4(x1) (0xFFC0A283), mem_ack delayed 3 cycles -> mem_req high 3 cycles, then WB with rf_we = 1, rf_wsel_mem = 1, imm = 0xFFFFFFFC.
- SW x2,8(x1) (0x0020A423), immediate mem_ack -> mem_we = 1, imm = 8, rf_we never high, pc_we pulse as MEM exits.
- BEQ x1,x2,+16 (0x00208863), branch_cond = 1 -> pc_we and pc_sel_branch high at T+2, imm = 16. Repeat with branch_cond = 0 -> pc_sel_branch = 0.
- 0xFFFFFFFF, then rst_n low during EXEC of ADDI -> illegal pulse once at T+2; reset forces IDLE, and no rf_we appears.
- MUL x3,x1,x2 (0x022081B3) -> alu_op = 11, rf_we at T+3 with CTRL_MUL_EN defined; illegal at T+2 without it.
